// File: rtl/lab_pkg.sv
// Shared constants, state encoding and address helpers for the plot capture block.
// No ports; imported by plot_capture and plot_capture_ram.
package lab_pkg;

  localparam int H_RES    = 160;
  localparam int V_RES    = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;
  localparam int ADDR_W   = 15;
  localparam int CNT_W    = 15;
  localparam int FB_DEPTH = H_RES * V_RES;

  typedef enum logic {CAP_CLEAR, CAP_IDLE} cap_state_t;

  // Linear framebuffer address; the multiply is by a constant so it reduces to shifts/adds.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
  endfunction

  function automatic logic in_bounds(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (int'(x) < H_RES) && (int'(y) < V_RES);
  endfunction

endpackage

// File: rtl/plot_capture_ram.sv
// Shadow framebuffer storage: FB_DEPTH words of {written, colour}.
// One write port plus two independent synchronous read ports (plot pipeline, readback).
// A read on the same edge as a write to the same address returns the old word.
// Ports: clk; we/waddr/wdata write; a_addr->a_data and b_addr->b_data registered reads.
module plot_capture_ram import lab_pkg::*; (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [COLOUR_W:0]   wdata,
  input  logic [ADDR_W-1:0]   a_addr,
  output logic [COLOUR_W:0]   a_data,
  input  logic [ADDR_W-1:0]   b_addr,
  output logic [COLOUR_W:0]   b_data
);

  logic [COLOUR_W:0] mem [FB_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    a_data <= mem[a_addr];
    b_data <= mem[b_addr];
  end

endmodule

// File: rtl/plot_capture.sv
// Sink for the pixel-plot interface: captures in-bounds plots into a 160x120 shadow
// framebuffer, counts unique pixels, flags out-of-bounds plots and offers a readback port.
// Ports: clk, rst (async, active-high); vga_x/vga_y/vga_colour/vga_plot plot input;
// clear (sweep start pulse); rd_req/rd_x/rd_y -> rd_valid/rd_colour readback;
// busy, pix_count, frame_done, oob_err, dup_count status.
// Optional feature macro: PLOT_DUP_CNT_EN enables the duplicate-plot counter (else dup_count=0).
module plot_capture import lab_pkg::*; (
  input  logic                clk,
  input  logic                rst,
  input  logic [X_W-1:0]      vga_x,
  input  logic [Y_W-1:0]      vga_y,
  input  logic [COLOUR_W-1:0] vga_colour,
  input  logic                vga_plot,
  input  logic                clear,
  input  logic                rd_req,
  input  logic [X_W-1:0]      rd_x,
  input  logic [Y_W-1:0]      rd_y,
  output logic                rd_valid,
  output logic [COLOUR_W-1:0] rd_colour,
  output logic                busy,
  output logic [CNT_W-1:0]    pix_count,
  output logic                frame_done,
  output logic                oob_err,
  output logic [CNT_W-1:0]    dup_count
);

  cap_state_t        state, next_state;
  logic [ADDR_W-1:0] clr_addr, next_clr_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CAP_CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= next_state;
      clr_addr <= next_clr_addr;
    end
  end

  always_comb begin
    next_state    = state;
    next_clr_addr = clr_addr;
    if (clear) begin
      next_state    = CAP_CLEAR;
      next_clr_addr = '0;
    end else if (state == CAP_CLEAR) begin
      if (clr_addr == ADDR_W'(FB_DEPTH - 1)) begin
        next_state    = CAP_IDLE;
        next_clr_addr = '0;
      end else begin
        next_clr_addr = clr_addr + ADDR_W'(1);
      end
    end
  end

  assign busy = (state == CAP_CLEAR);

  // Stage p0: sample plot and readback requests, issue RAM reads
  logic              plot_inb, plot_take, rd_inb;
  logic [ADDR_W-1:0] plot_addr, rd_addr;
  logic [COLOUR_W:0] ra_data, rb_data;

  assign plot_inb  = in_bounds(vga_x, vga_y);
  assign plot_addr = plot_inb ? fb_addr(vga_x, vga_y) : '0;
  // A plot coinciding with a clear pulse would land after the sweep has begun, so drop it.
  assign plot_take = vga_plot && (state == CAP_IDLE) && !clear && plot_inb;
  assign rd_inb    = in_bounds(rd_x, rd_y);
  assign rd_addr   = rd_inb ? fb_addr(rd_x, rd_y) : '0;

  // Stage p1: commit plot, update counters; register readback word
  logic                vld_p1, vld_p2, rd_vld_p1, rd_inb_p1;
  logic [ADDR_W-1:0]   addr_p1, addr_p2;
  logic [COLOUR_W-1:0] colour_p1;
  logic                written_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      rd_vld_p1 <= 1'b0;
      rd_inb_p1 <= 1'b0;
    end else begin
      vld_p1    <= plot_take;
      vld_p2    <= vld_p1;
      rd_vld_p1 <= rd_req;
      rd_inb_p1 <= rd_inb;
    end
  end

  always_ff @(posedge clk) begin
    addr_p1   <= plot_addr;
    colour_p1 <= vga_colour;
    addr_p2   <= addr_p1;
  end

  // The RAM read for this plot was issued on the same edge the previous plot committed,
  // so a back-to-back hit on the same address must take written=1 from the commit stage.
  assign written_p1 = ra_data[COLOUR_W] | (vld_p2 && (addr_p2 == addr_p1));

  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [COLOUR_W:0]   wdata;

  always_comb begin
    we    = 1'b0;
    waddr = clr_addr;
    wdata = '0;
    if (state == CAP_CLEAR) begin
      we = 1'b1;
    end else if (vld_p1) begin
      we    = 1'b1;
      waddr = addr_p1;
      wdata = {1'b1, colour_p1};
    end
  end

  plot_capture_ram u_ram (
    .clk    (clk),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .a_addr (plot_addr),
    .a_data (ra_data),
    .b_addr (rd_addr),
    .b_data (rb_data)
  );

  // Only the written flag matters to the plot pipeline.
  logic [COLOUR_W-1:0] unused_plot_colour;
  assign unused_plot_colour = ra_data[COLOUR_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_count <= '0;
      oob_err   <= 1'b0;
    end else begin
      if (clear)
        pix_count <= '0;
      else if (vld_p1 && !written_p1 && (pix_count != CNT_W'(FB_DEPTH)))
        pix_count <= pix_count + CNT_W'(1);
      if (vga_plot && (state == CAP_IDLE) && !plot_inb)
        oob_err <= 1'b1;
    end
  end

  assign frame_done = (pix_count == CNT_W'(FB_DEPTH));

`ifdef PLOT_DUP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      dup_count <= '0;
    else if (clear)
      dup_count <= '0;
    else if (vld_p1 && written_p1 && (dup_count != '1))
      dup_count <= dup_count + CNT_W'(1);
  end
`else
  assign dup_count = '0;
`endif

  // Stage p2: readback output register (never-written and out-of-bounds read as 0)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid  <= 1'b0;
      rd_colour <= '0;
    end else begin
      rd_valid <= rd_vld_p1;
      if (rd_vld_p1)
        rd_colour <= (rd_inb_p1 && rb_data[COLOUR_W]) ? rb_data[COLOUR_W-1:0] : '0;
    end
  end

endmodule

// File: tb/tb_plot_capture.sv
// Self-checking bench for plot_capture with a framebuffer reference model (-1 = never written).
module tb_plot_capture;
  localparam int H = 160;
  localparam int V = 120;
  localparam int FB = H * V;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  vga_x = '0;
  logic [6:0]  vga_y = '0;
  logic [2:0]  vga_colour = '0;
  logic        vga_plot = 1'b0;
  logic        clear = 1'b0;
  logic        rd_req = 1'b0;
  logic [7:0]  rd_x = '0;
  logic [6:0]  rd_y = '0;
  logic        rd_valid;
  logic [2:0]  rd_colour;
  logic        busy;
  logic [14:0] pix_count;
  logic        frame_done;
  logic        oob_err;
  logic [14:0] dup_count;

  plot_capture dut (
    .clk(clk), .rst(rst), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .clear(clear), .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y),
    .rd_valid(rd_valid), .rd_colour(rd_colour), .busy(busy), .pix_count(pix_count),
    .frame_done(frame_done), .oob_err(oob_err), .dup_count(dup_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ref_mem [FB];
  int ref_pix = 0;
  int ref_dup = 0;
  bit ref_oob = 1'b0;
  int touched [$];

  function automatic int exp_dup();
`ifdef PLOT_DUP_CNT_EN
    return ref_dup;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_col(input int x, input int y);
    if (x >= H || y >= V) return 0;
    return (ref_mem[y*H + x] < 0) ? 0 : ref_mem[y*H + x];
  endfunction

  task automatic model_clear();
    foreach (ref_mem[i]) ref_mem[i] = -1;
    ref_pix = 0;
    ref_dup = 0;
  endtask

  // One plot strobe, sampled at the next rising edge; model applies it immediately.
  task automatic plot(input int x, input int y, input int c);
    @(negedge clk);
    vga_x = x[7:0]; vga_y = y[6:0]; vga_colour = c[2:0]; vga_plot = 1'b1;
    @(posedge clk); #1;
    if (x < H && y < V) begin
      if (ref_mem[y*H + x] < 0) ref_pix++; else ref_dup++;
      ref_mem[y*H + x] = c;
    end else begin
      ref_oob = 1'b1;
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    vga_plot = 1'b0; rd_req = 1'b0; clear = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic read_px(input int x, input int y, output logic v, output logic [2:0] c);
    @(negedge clk);
    vga_plot = 1'b0; rd_req = 1'b1; rd_x = x[7:0]; rd_y = y[6:0];
    @(posedge clk); #1;
    @(negedge clk);
    rd_req = 1'b0;
    @(posedge clk); #1;
    v = rd_valid; c = rd_colour;
  endtask

  // Counts edges until busy drops (bounded); optionally injects one plot during the sweep.
  task automatic wait_idle(input int plot_at, output int n);
    n = 0;
    while (busy && n < 20000) begin
      vga_plot = (n == plot_at);
      vga_x = 8'd3; vga_y = 7'd3; vga_colour = 3'd7;
      @(posedge clk); #1;
      n++;
    end
    vga_plot = 1'b0;
  endtask

  task automatic test_reset();
    logic v; logic [2:0] c; int n;
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_busy got=%0b want=1", busy); end
    checks++; if (pix_count !== 15'd0) begin failures++; $display("FAIL rst_pix got=%0d want=0", pix_count); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL rst_frame_done got=%0b want=0", frame_done); end
    checks++; if (oob_err !== 1'b0) begin failures++; $display("FAIL rst_oob got=%0b want=0", oob_err); end
    checks++; if (rd_valid !== 1'b0 || rd_colour !== 3'd0) begin failures++; $display("FAIL rst_rd got=%0b/%0d want=0/0", rd_valid, rd_colour); end
    checks++; if (dup_count !== 15'd0) begin failures++; $display("FAIL rst_dup got=%0d want=0", dup_count); end
    @(negedge clk); rst = 1'b0;
    model_clear(); ref_oob = 1'b0;
    wait_idle(-1, n);
    checks++; if (n != FB) begin failures++; $display("FAIL rst_busy_len got=%0d want=%0d", n, FB); end
    checks++; if (pix_count !== 15'd0) begin failures++; $display("FAIL rst_pix_after got=%0d want=0", pix_count); end
    read_px(0, 0, v, c);
    checks++; if (v !== 1'b1 || c !== 3'd0) begin failures++; $display("FAIL rst_rd00 got=%0b/%0d want=1/0", v, c); end
    @(posedge clk); #1;
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rd_valid_pulse got=%0b want=0", rd_valid); end
  endtask

  task automatic test_back_to_back();
    logic v; logic [2:0] c;
    plot(10, 10, 1);
    plot(10, 10, 2);
    idle_cycle();
    checks++; if (pix_count !== 15'(ref_pix) || ref_pix != 1) begin failures++; $display("FAIL b2b_pix got=%0d want=1", pix_count); end
    checks++; if (dup_count !== 15'(exp_dup())) begin failures++; $display("FAIL b2b_dup got=%0d want=%0d", dup_count, exp_dup()); end
    read_px(10, 10, v, c);
    checks++; if (v !== 1'b1 || c !== 3'd2) begin failures++; $display("FAIL b2b_rd got=%0b/%0d want=1/2", v, c); end
    plot(20, 20, 4); idle_cycle(); plot(20, 20, 5); idle_cycle();
    checks++; if (pix_count !== 15'(ref_pix) || dup_count !== 15'(exp_dup())) begin failures++; $display("FAIL gap_dup got=%0d/%0d want=%0d/%0d", pix_count, dup_count, ref_pix, exp_dup()); end
    // Dense random burst in a 4x4 corner stresses same-address forwarding.
    for (int i = 0; i < 200; i++) plot(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
    idle_cycle();
    checks++; if (pix_count !== 15'(ref_pix)) begin failures++; $display("FAIL burst_pix got=%0d want=%0d", pix_count, ref_pix); end
    checks++; if (dup_count !== 15'(exp_dup())) begin failures++; $display("FAIL burst_dup got=%0d want=%0d", dup_count, exp_dup()); end
    for (int yy = 0; yy < 4; yy++)
      for (int xx = 0; xx < 4; xx++) begin
        read_px(xx, yy, v, c);
        checks++; if (c !== 3'(exp_col(xx, yy))) begin failures++; $display("FAIL burst_rd(%0d,%0d) got=%0d want=%0d", xx, yy, c, exp_col(xx, yy)); end
      end
    checks++; if (oob_err !== 1'b0) begin failures++; $display("FAIL oob_idle got=%0b want=0", oob_err); end
  endtask

  task automatic test_random();
    logic v; logic [2:0] c; int x, y;
    touched.delete();
    for (int i = 0; i < 500; i++) begin
      x = int'($urandom_range(0, H-1)); y = int'($urandom_range(0, V-1));
      plot(x, y, int'($urandom_range(0, 7)));
      touched.push_back(y*H + x);
    end
    idle_cycle();
    checks++; if (pix_count !== 15'(ref_pix)) begin failures++; $display("FAIL rand_pix got=%0d want=%0d", pix_count, ref_pix); end
    checks++; if (dup_count !== 15'(exp_dup())) begin failures++; $display("FAIL rand_dup got=%0d want=%0d", dup_count, exp_dup()); end
    for (int k = 0; k < 8; k++) begin
      x = touched[k*60] % H; y = touched[k*60] / H;
      read_px(x, y, v, c);
      checks++; if (v !== 1'b1 || c !== 3'(exp_col(x, y))) begin failures++; $display("FAIL rand_rd(%0d,%0d) got=%0b/%0d want=1/%0d", x, y, v, c, exp_col(x, y)); end
    end
  endtask

  task automatic test_clear();
    logic v; logic [2:0] c; int n;
    @(negedge clk); clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
    model_clear();
    checks++; if (pix_count !== 15'd0 || dup_count !== 15'd0 || busy !== 1'b1) begin failures++; $display("FAIL clr_zero got=%0d/%0d/%0b want=0/0/1", pix_count, dup_count, busy); end
    wait_idle(100, n);
    checks++; if (n != FB) begin failures++; $display("FAIL clr_busy_len got=%0d want=%0d", n, FB); end
    checks++; if (pix_count !== 15'd0) begin failures++; $display("FAIL clr_pix got=%0d want=0", pix_count); end
    read_px(3, 3, v, c);
    checks++; if (c !== 3'd0) begin failures++; $display("FAIL clr_swept_plot got=%0d want=0", c); end
    read_px(touched[7] % H, touched[7] / H, v, c);
    checks++; if (c !== 3'd0) begin failures++; $display("FAIL clr_old_px got=%0d want=0", c); end
    checks++; if (oob_err !== 1'b0) begin failures++; $display("FAIL clr_oob got=%0b want=0", oob_err); end
  endtask

  task automatic test_raster();
    logic v; logic [2:0] c; int x, y;
    for (int yy = 0; yy < V; yy++)
      for (int xx = 0; xx < H; xx++) plot(xx, yy, xx & 7);
    checks++; if (frame_done !== 1'b0 || pix_count !== 15'(FB-1)) begin failures++; $display("FAIL raster_pre got=%0b/%0d want=0/%0d", frame_done, pix_count, FB-1); end
    idle_cycle();
    checks++; if (frame_done !== 1'b1 || pix_count !== 15'(ref_pix) || ref_pix != FB) begin failures++; $display("FAIL raster_done got=%0b/%0d want=1/%0d", frame_done, pix_count, FB); end
    checks++; if (dup_count !== 15'(exp_dup())) begin failures++; $display("FAIL raster_dup got=%0d want=%0d", dup_count, exp_dup()); end
    read_px(37, 5, v, c);
    checks++; if (v !== 1'b1 || c !== 3'd5) begin failures++; $display("FAIL raster_rd37_5 got=%0b/%0d want=1/5", v, c); end
    for (int k = 0; k < 6; k++) begin
      x = int'($urandom_range(0, H-1)); y = int'($urandom_range(0, V-1));
      read_px(x, y, v, c);
      checks++; if (c !== 3'(exp_col(x, y))) begin failures++; $display("FAIL raster_rd(%0d,%0d) got=%0d want=%0d", x, y, c, exp_col(x, y)); end
    end
  endtask

  task automatic test_oob();
    logic v; logic [2:0] c;
    plot(160, 0, 6);
    plot(0, 120, 6);
    idle_cycle();
    checks++; if (oob_err !== 1'b1 || !ref_oob) begin failures++; $display("FAIL oob_flag got=%0b want=1", oob_err); end
    checks++; if (pix_count !== 15'(ref_pix) || dup_count !== 15'(exp_dup())) begin failures++; $display("FAIL oob_counts got=%0d/%0d want=%0d/%0d", pix_count, dup_count, ref_pix, exp_dup()); end
    read_px(0, 1, v, c);
    checks++; if (c !== 3'(exp_col(0, 1))) begin failures++; $display("FAIL oob_alias got=%0d want=%0d", c, exp_col(0, 1)); end
    read_px(203, 5, v, c);
    checks++; if (v !== 1'b1 || c !== 3'd0) begin failures++; $display("FAIL oob_rd got=%0b/%0d want=1/0", v, c); end
  endtask

  task automatic test_rst_mid();
    plot(60, 60, 3);
    rst = 1'b1; #1;
    checks++; if (pix_count !== 15'd0 || busy !== 1'b1 || frame_done !== 1'b0) begin failures++; $display("FAIL rstmid_async got=%0d/%0b/%0b want=0/1/0", pix_count, busy, frame_done); end
    checks++; if (oob_err !== 1'b0 || rd_valid !== 1'b0) begin failures++; $display("FAIL rstmid_flags got=%0b/%0b want=0/0", oob_err, rd_valid); end
    @(negedge clk); rst = 1'b0; vga_plot = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (pix_count !== 15'd0 || busy !== 1'b1) begin failures++; $display("FAIL rstmid_after got=%0d/%0b want=0/1", pix_count, busy); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_random();
    test_clear();
    test_raster();
    test_oob();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
